// File: rtl/gsr_ctrl.sv
// rtl/gsr_ctrl.sv - global set/reset sequencer: immediate assert, lock-qualified timed release
// Soft requests re-run the release sequence; ack marks the first RUN cycle after servicing one.
module gsr_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2,
  parameter int REQ_MIN     = 4
) (
  input  logic clk,
  input  logic sr,
  input  logic ce,
  input  logic lock,
  input  logic req,
  output logic gsrn,
  output logic ready,
  output logic ack
);

  localparam int MAXC = (HOLD_CYCLES > REQ_MIN) ? HOLD_CYCLES : REQ_MIN;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST  = CW'(REQ_MIN - 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RUN, ST_SOFT} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_q;
  logic                   pend;
  logic                   lock_s;
  logic                   req_rise;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign req_rise = req & ~req_q;

  // Outputs are assigned alongside the state they belong to, so they always
  // reflect the state being entered on this edge.
  always_ff @(posedge clk or posedge sr) begin
    if (sr) begin
      state  <= ST_ASSERT;
      count  <= '0;
      sync_q <= '0;
      req_q  <= 1'b0;
      pend   <= 1'b0;
      gsrn   <= 1'b0;
      ready  <= 1'b0;
      ack    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
      req_q  <= req;
      ack    <= 1'b0;
      if (req_rise) pend <= 1'b1;

      case (state)
        ST_ASSERT: begin
          gsrn  <= 1'b0;
          ready <= 1'b0;
          if (lock_s) begin
            state <= ST_HOLD;
            count <= '0;
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state <= ST_ASSERT;
            count <= '0;
          end else if (ce) begin
            if (count == HOLD_LAST) begin
              state <= ST_RUN;
              count <= '0;
              gsrn  <= 1'b1;
              ready <= 1'b1;
              ack   <= pend;
              pend  <= req_rise;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state <= ST_ASSERT;
            count <= '0;
            gsrn  <= 1'b0;
            ready <= 1'b0;
          end else if (req_rise) begin
            state <= ST_SOFT;
            count <= '0;
            gsrn  <= 1'b0;
            ready <= 1'b0;
          end
        end
        ST_SOFT: begin
          if (!lock_s) begin
            state <= ST_ASSERT;
            count <= '0;
          end else if (count == REQ_LAST) begin
            state <= ST_HOLD;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= ST_ASSERT;
          count <= '0;
          gsrn  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsr_ctrl.sv
// tb/tb_gsr_ctrl.sv - scoreboard bench for gsr_ctrl
module tb_gsr_ctrl;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_ACK  = 2;

  typedef struct {
    int kind;
    int edge_n;
  } ev_t;

  logic clk;
  logic sr;
  logic ce;
  logic lock;
  logic req;
  logic gsrn;
  logic ready;
  logic ack;

  int   ecnt   = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  logic prev_g = 1'b0;
  ev_t  exp_q[$];

  gsr_ctrl #(.HOLD_CYCLES(16), .SYNC_STAGES(2), .REQ_MIN(4)) dut (
    .clk   (clk),
    .sr    (sr),
    .ce    (ce),
    .lock  (lock),
    .req   (req),
    .gsrn  (gsrn),
    .ready (ready),
    .ack   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d at edge %0d, none expected", kind, ecnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.edge_n != ecnt) begin
        errors++;
        $display("FAIL event_match: got kind=%0d edge=%0d, expected kind=%0d edge=%0d",
                 kind, ecnt, e.kind, e.edge_n);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ready !== gsrn) begin
        errors++;
        $display("FAIL ready_eq_gsrn: ready=%b gsrn=%b at edge %0d", ready, gsrn, ecnt);
      end
      if (gsrn !== prev_g) begin
        observe(gsrn ? EV_RISE : EV_FALL);
        prev_g <= gsrn;
      end
      if (ack === 1'b1) observe(EV_ACK);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int edge_n);
    ev_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events not seen, next kind=%0d edge=%0d",
               name, exp_q.size(), exp_q[0].kind, exp_q[0].edge_n);
      exp_q.delete();
    end
  endtask

  task automatic sr_hit(input string name, input bit was_high);
    int n;
    n  = ecnt;
    sr = 1'b1;
    #1;
    chk({name, "_gsrn"}, gsrn, 1'b0);
    chk({name, "_ready"}, ready, 1'b0);
    chk({name, "_ack"}, ack, 1'b0);
    if (was_high) push(EV_FALL, n + 1);
  endtask

  initial begin
    int n;
    sr   = 1'b0;
    ce   = 1'b1;
    lock = 1'b1;
    req  = 1'b0;
    #2 sr = 1'b1;
    tick(3);
    chk("reset_gsrn", gsrn, 1'b0);
    chk("reset_ready", ready, 1'b0);
    chk("reset_ack", ack, 1'b0);
    mon_en = 1'b1;

    // 1: basic release at E18
    n  = ecnt;
    sr = 1'b0;
    push(EV_RISE, n + 19);
    tick(25);
    drain("t1_release");
    chk("t1_gsrn_high", gsrn, 1'b1);
    chk("t1_ready_high", ready, 1'b1);

    // 2: ce low for 5 HOLD edges delays release to E23
    sr_hit("t2_sr", 1'b1);
    tick(2);
    n  = ecnt;
    sr = 1'b0;
    tick(5);
    ce = 1'b0;
    tick(5);
    ce = 1'b1;
    push(EV_RISE, n + 24);
    tick(20);
    drain("t2_ce_freeze");

    // 3: held-high req gives one 20-cycle low pulse and one ack
    n   = ecnt;
    req = 1'b1;
    push(EV_FALL, n + 1);
    push(EV_RISE, n + 21);
    push(EV_ACK,  n + 21);
    tick(40);
    req = 1'b0;
    tick(5);
    drain("t3_soft_req");

    // 4: one-cycle lock drop in HOLD restarts the sequence
    sr_hit("t4_sr", 1'b1);
    tick(2);
    n  = ecnt;
    sr = 1'b0;
    tick(5);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    push(EV_RISE, n + 25);
    tick(30);
    drain("t4_lock_drop");

    // 5: request in HOLD survives lock loss and is acked on RUN entry
    sr_hit("t5_sr", 1'b1);
    tick(2);
    n  = ecnt;
    sr = 1'b0;
    tick(4);
    req = 1'b1;
    tick(2);
    req = 1'b0;
    tick(1);
    lock = 1'b0;
    tick(3);
    lock = 1'b1;
    push(EV_RISE, n + 29);
    push(EV_ACK,  n + 29);
    tick(25);
    drain("t5_pend_ack");

    // 6a: sr mid-SOFT clears the pending request
    n   = ecnt;
    req = 1'b1;
    push(EV_FALL, n + 1);
    tick(2);
    req = 1'b0;
    sr_hit("t6a_sr", 1'b0);
    tick(2);
    n  = ecnt;
    sr = 1'b0;
    push(EV_RISE, n + 19);
    tick(25);
    drain("t6a_sr_soft");

    // 6b: sr mid-RUN
    chk("t6b_pre_gsrn", gsrn, 1'b1);
    sr_hit("t6b_sr", 1'b1);
    tick(2);
    n  = ecnt;
    sr = 1'b0;
    push(EV_RISE, n + 19);
    tick(25);
    drain("t6b_sr_run");
    chk("t6b_final_gsrn", gsrn, 1'b1);
    chk("t6b_final_ack", ack, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
